// File: rtl/paddle_controller_multi_pkg.sv
// ---------------------------------------------------------------------------
// paddle_controller_multi_pkg
// Shared types and default screen constants for the multi-paddle controller.
//   dir_t         : requested direction decoded from the synchronised buttons
//   axis_state_t  : per-paddle state machine states
//   decode_dir()  : plus/minus -> direction, simultaneous press cancels
// ---------------------------------------------------------------------------
package paddle_controller_multi_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD_UP = 2'd1,
    ST_HOLD_DN = 2'd2
  } axis_state_t;

  localparam int SCREEN_H_DEF    = 480;
  localparam int Y_RESET_DEF     = 240;
  localparam int HALF_NORMAL_DEF = 50;
  localparam int HALF_SMALL_DEF  = 40;

  // Both or neither pressed means no movement; there is no priority.
  function automatic dir_t decode_dir(input logic plus, input logic minus);
    dir_t d;
    d = DIR_NONE;
    if (plus && !minus) begin
      d = DIR_UP;
    end else if (minus && !plus) begin
      d = DIR_DN;
    end
    return d;
  endfunction

endpackage

// File: rtl/paddle_controller_multi_paddle_axis.sv
// ---------------------------------------------------------------------------
// paddle_axis
// One paddle: hold-to-accelerate state machine, step/hold counters and
// range clamp of the centre Y coordinate.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   tick       : movement strobe; the state machine only advances on it
//   size_sel   : 1 = small half-height, 0 = normal half-height (live)
//   dir        : synchronised requested direction
//   y          : registered paddle centre Y
// ---------------------------------------------------------------------------
module paddle_axis
  import paddle_controller_multi_pkg::*;
#(
  parameter int Y_W         = 11,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int Y_RESET     = Y_RESET_DEF,
  parameter int HALF_NORMAL = HALF_NORMAL_DEF,
  parameter int HALF_SMALL  = HALF_SMALL_DEF,
  parameter int ACCEL_TICKS = 16,
  parameter int MAX_STEP    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           size_sel,
  input  dir_t           dir,
  output logic [Y_W-1:0] y
);

  localparam int STEP_W = 4;
  localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

  localparam logic [Y_W:0]        SCREEN_H_X    = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W:0]        HALF_NORMAL_X = (Y_W+1)'(HALF_NORMAL);
  localparam logic [Y_W:0]        HALF_SMALL_X  = (Y_W+1)'(HALF_SMALL);
  localparam logic [Y_W-1:0]      Y_RESET_Y     = Y_W'(Y_RESET);
  localparam logic [STEP_W-1:0]   ONE_STEP      = STEP_W'(1);
  localparam logic [STEP_W-1:0]   MAX_STEP_S    = STEP_W'(MAX_STEP);
  localparam logic [HOLD_W-1:0]   HOLD_LAST     = HOLD_W'(ACCEL_TICKS - 1);

  axis_state_t         state_reg, state_next;
  logic [STEP_W-1:0]   step_reg, step_next, step_cur;
  logic [HOLD_W-1:0]   hold_reg, hold_next, hold_cur;
  logic [Y_W-1:0]      y_reg, y_next;
  logic [Y_W:0]        half, lo, hi, y_ext, step_ext, y_sum;
  logic                move_up, move_dn;

  always_comb begin
    half = size_sel ? HALF_SMALL_X : HALF_NORMAL_X;
    lo   = half;
    hi   = SCREEN_H_X - half;

    state_next = state_reg;
    step_next  = step_reg;
    hold_next  = hold_reg;
    step_cur   = step_reg;
    hold_cur   = hold_reg;
    move_up    = 1'b0;
    move_dn    = 1'b0;

    if (tick) begin
      case (dir)
        DIR_UP: begin
          // A fresh or reversed direction restarts from step 1.
          if (state_reg != ST_HOLD_UP) begin
            step_cur = ONE_STEP;
            hold_cur = '0;
          end
          state_next = ST_HOLD_UP;
          move_up    = 1'b1;
        end
        DIR_DN: begin
          if (state_reg != ST_HOLD_DN) begin
            step_cur = ONE_STEP;
            hold_cur = '0;
          end
          state_next = ST_HOLD_DN;
          move_dn    = 1'b1;
        end
        default: begin
          state_next = ST_IDLE;
          step_next  = ONE_STEP;
          hold_next  = '0;
        end
      endcase

      // Every moving tick, including the one that enters a HOLD state,
      // counts as a held tick; after ACCEL_TICKS of them the step grows.
      if (move_up || move_dn) begin
        if (hold_cur == HOLD_LAST) begin
          hold_next = '0;
          step_next = (step_cur >= MAX_STEP_S) ? MAX_STEP_S : step_cur + 1'b1;
        end else begin
          hold_next = hold_cur + 1'b1;
          step_next = step_cur;
        end
      end
    end

    // One extra bit of headroom so y + step can never wrap.
    y_ext    = {1'b0, y_reg};
    step_ext = (Y_W+1)'(step_cur);
    y_sum    = y_ext + step_ext;

    // Out-of-range (e.g. after a size change) wins over any tick move.
    y_next = y_reg;
    if (y_ext < lo) begin
      y_next = lo[Y_W-1:0];
    end else if (y_ext > hi) begin
      y_next = hi[Y_W-1:0];
    end else if (move_up) begin
      y_next = (y_sum > hi) ? hi[Y_W-1:0] : y_sum[Y_W-1:0];
    end else if (move_dn) begin
      y_next = (y_ext < lo + step_ext) ? lo[Y_W-1:0] : y_reg - Y_W'(step_cur);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= ONE_STEP;
      hold_reg  <= '0;
      y_reg     <= Y_RESET_Y;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      hold_reg  <= hold_next;
      y_reg     <= y_next;
    end
  end

  assign y = y_reg;

endmodule

// File: rtl/paddle_controller_multi.sv
// ---------------------------------------------------------------------------
// paddle_controller_multi
// Button-driven centre-Y controller for NUM_PADDLES independent paddles.
// Holds the shared movement tick divider and the button synchronisers;
// each paddle's motion lives in a paddle_axis instance.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   btn_plus_n   : active-low "increase Y" buttons (async), bit i = paddle i
//   btn_minus_n  : active-low "decrease Y" buttons (async)
//   size_sel     : per-paddle size, 1 = small, 0 = normal (synchronous)
//   paddle_y     : packed centre Y, paddle i at [i*Y_W +: Y_W]
//   moving       : paddle i has a valid (non-cancelled) direction held
//   tick         : one-cycle movement strobe
// ---------------------------------------------------------------------------
module paddle_controller_multi
  import paddle_controller_multi_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int Y_W         = 11,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int Y_RESET     = Y_RESET_DEF,
  parameter int HALF_NORMAL = HALF_NORMAL_DEF,
  parameter int HALF_SMALL  = HALF_SMALL_DEF,
  parameter int TICK_DIV    = 131072,
  parameter int ACCEL_TICKS = 16,
  parameter int MAX_STEP    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PADDLES-1:0]     btn_plus_n,
  input  logic [NUM_PADDLES-1:0]     btn_minus_n,
  input  logic [NUM_PADDLES-1:0]     size_sel,
  output logic [NUM_PADDLES*Y_W-1:0] paddle_y,
  output logic [NUM_PADDLES-1:0]     moving,
  output logic                       tick
);

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]       cnt_reg;
  logic [NUM_PADDLES-1:0] plus_meta_reg, plus_sync_reg;
  logic [NUM_PADDLES-1:0] minus_meta_reg, minus_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == CNT_LAST);

  // Buttons are kept active-low through the synchroniser so that reset
  // (all ones) reads as "released".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plus_meta_reg  <= '1;
      plus_sync_reg  <= '1;
      minus_meta_reg <= '1;
      minus_sync_reg <= '1;
    end else begin
      plus_meta_reg  <= btn_plus_n;
      plus_sync_reg  <= plus_meta_reg;
      minus_meta_reg <= btn_minus_n;
      minus_sync_reg <= minus_meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADDLES; gi++) begin : g_paddle
      dir_t dir;

      assign dir        = decode_dir(~plus_sync_reg[gi], ~minus_sync_reg[gi]);
      assign moving[gi] = (dir != DIR_NONE);

      paddle_axis #(
        .Y_W         (Y_W),
        .SCREEN_H    (SCREEN_H),
        .Y_RESET     (Y_RESET),
        .HALF_NORMAL (HALF_NORMAL),
        .HALF_SMALL  (HALF_SMALL),
        .ACCEL_TICKS (ACCEL_TICKS),
        .MAX_STEP    (MAX_STEP)
      ) u_axis (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .size_sel (size_sel[gi]),
        .dir      (dir),
        .y        (paddle_y[gi*Y_W +: Y_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_paddle_controller_multi.sv
// ---------------------------------------------------------------------------
// tb_paddle_controller_multi
// Directed stimulus with a behavioural model: per paddle the model keeps
// only the position and the length of the current run of held ticks; the
// step is min(1 + run/ACCEL_TICKS, MAX_STEP). Literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_paddle_controller_multi;

  localparam int NP  = 2;
  localparam int Y_W = 11;
  localparam int SH  = 480;
  localparam int YR  = 240;
  localparam int HN  = 50;
  localparam int HS  = 40;
  localparam int TD  = 4;
  localparam int AT  = 2;
  localparam int MS  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       btn_plus_n, btn_minus_n, size_sel;
  logic [NP*Y_W-1:0]   paddle_y;
  logic [NP-1:0]       moving;
  logic                tick;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  paddle_controller_multi #(
    .NUM_PADDLES (NP),
    .Y_W         (Y_W),
    .TICK_DIV    (TD),
    .ACCEL_TICKS (AT),
    .MAX_STEP    (MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_plus_n  (btn_plus_n),
    .btn_minus_n (btn_minus_n),
    .size_sel    (size_sel),
    .paddle_y    (paddle_y),
    .moving      (moving),
    .tick        (tick)
  );

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int y_of(int i);
    return int'(paddle_y[i*Y_W +: Y_W]);
  endfunction

  // ---------------- behavioural model ----------------
  int m_y[NP];
  int m_run[NP];
  int m_last[NP];
  int m_cnt;
  bit m_p1[NP], m_p2[NP], m_m1[NP], m_m2[NP];

  function automatic int m_dir(int i);
    if (m_p2[i] && !m_m2[i]) return 1;
    if (m_m2[i] && !m_p2[i]) return -1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    int half, lo, hi, d, ny, st;
    bit t;
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < NP; i++) begin
        m_y[i] = YR; m_run[i] = 0; m_last[i] = 0;
        m_p1[i] = 0; m_p2[i] = 0; m_m1[i] = 0; m_m2[i] = 0;
      end
    end else begin
      t = (m_cnt == TD - 1);
      for (int i = 0; i < NP; i++) begin
        half = size_sel[i] ? HS : HN;
        lo = half;
        hi = SH - half;
        d  = m_dir(i);
        ny = m_y[i];
        if (t) begin
          if (d == 0) begin
            m_run[i] = 0;
          end else begin
            if (d != m_last[i]) m_run[i] = 0;
            st = 1 + m_run[i] / AT;
            if (st > MS) st = MS;
            if (d > 0) ny = (m_y[i] + st > hi) ? hi : m_y[i] + st;
            else       ny = (m_y[i] - st < lo) ? lo : m_y[i] - st;
            m_run[i]++;
          end
          m_last[i] = d;
        end
        if (m_y[i] < lo) ny = lo;
        else if (m_y[i] > hi) ny = hi;
        m_y[i] = ny;
        m_p2[i] = m_p1[i]; m_p1[i] = !btn_plus_n[i];
        m_m2[i] = m_m1[i]; m_m1[i] = !btn_minus_n[i];
      end
      m_cnt = (m_cnt + 1) % TD;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("tick", int'(tick), int'(m_cnt == TD - 1));
      for (int i = 0; i < NP; i++) begin
        check($sformatf("y%0d", i), y_of(i), m_y[i]);
        check($sformatf("moving%0d", i), int'(moving[i]), int'(m_dir(i) != 0));
      end
    end
  end

  // Waits for a tick and returns at the negedge after the move landed.
  task automatic wait_tick_done();
    int g;
    g = 0;
    while (tick !== 1'b1 && g < 4 * TD) begin
      @(negedge clk);
      g++;
    end
    if (tick !== 1'b1) check("tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  int exp0[8] = '{241, 242, 244, 246, 249, 252, 255, 258};

  initial begin
    rst = 1'b1;
    btn_plus_n  = '1;
    btn_minus_n = '1;
    size_sel    = '0;
    repeat (2) @(negedge clk);
    check("rst_y0", y_of(0), 240);
    check("rst_y1", y_of(1), 240);
    check("rst_tick", int'(tick), 0);
    check("rst_moving", int'(moving), 0);

    // Tick at cycles 3, 7, 11 after release.
    rst = 1'b0;
    chk_en = 1'b1;
    for (int n = 0; n < 12; n++) begin
      check("tick_pat", int'(tick), int'(n == 3 || n == 7 || n == 11));
      @(negedge clk);
    end

    // Hold plus on paddle 0 for 8 ticks.
    btn_plus_n[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_tick_done();
      check("accel_y0", y_of(0), exp0[k]);
      check("accel_y1", y_of(1), 240);
    end

    // Cancel on paddle 1, then release minus only.
    btn_plus_n[0]  = 1'b1;
    btn_plus_n[1]  = 1'b0;
    btn_minus_n[1] = 1'b0;
    wait_tick_done();
    check("cancel_moving1", int'(moving[1]), 0);
    check("cancel_y1", y_of(1), 240);
    check("idle_y0", y_of(0), 258);
    btn_minus_n[1] = 1'b1;
    wait_tick_done();
    check("restart_y1", y_of(1), 241);
    check("restart_moving1", int'(moving[1]), 1);
    wait_tick_done();
    check("restart2_y1", y_of(1), 242);
    btn_plus_n[1] = 1'b1;

    // Paddle 0 up into the normal-size top limit.
    btn_plus_n[0] = 1'b0;
    repeat (70) wait_tick_done();
    check("hi_clamp_y0", y_of(0), 430);
    wait_tick_done();
    check("hi_hold_y0", y_of(0), 430);
    check("hi_moving0", int'(moving[0]), 1);

    // Small size at 430 stays in range.
    btn_plus_n[0] = 1'b1;
    wait_tick_done();
    size_sel[0] = 1'b1;
    @(negedge clk);
    check("small_keep_y0", y_of(0), 430);
    wait_tick_done();
    check("small_keep2_y0", y_of(0), 430);

    // Down to the small-size bottom limit.
    btn_minus_n[0] = 1'b0;
    repeat (160) wait_tick_done();
    check("lo_clamp_y0", y_of(0), 40);
    btn_minus_n[0] = 1'b1;

    // Up to 440 under small size, then back to normal size.
    btn_plus_n[0] = 1'b0;
    repeat (160) wait_tick_done();
    check("small_hi_y0", y_of(0), 440);
    btn_plus_n[0] = 1'b1;
    wait_tick_done();
    size_sel[0] = 1'b0;
    @(negedge clk);
    check("resize_clamp_y0", y_of(0), 430);

    // Reset in the middle of an accelerated hold on paddle 1.
    btn_plus_n[1] = 1'b0;
    repeat (6) wait_tick_done();
    check("prereset_y1", y_of(1), 242 + 1 + 1 + 2 + 2 + 3 + 3);
    rst = 1'b1;
    #1;
    check("async_rst_y1", y_of(1), 240);
    check("async_rst_y0", y_of(0), 240);
    check("async_rst_tick", int'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick_done();
    check("post_rst_y1", y_of(1), 241);
    check("post_rst_y0", y_of(0), 240);
    btn_plus_n[1] = 1'b1;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
